// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// -----------------------------------------------------------------------------
// Execute stage and EX/MEM pipeline register for the 5-stage MIPS pipeline.
// Takes the ID/EX register outputs, resolves operand hazards by forwarding
// from the EX/MEM register (this block's own outputs) and from the WB stage,
// decodes the ALU operation from aluop/funct, evaluates the ALU, selects the
// destination register and registers everything for the memory stage.
// Latency is one cycle; the stage advances on every clock edge.
//
// Optional build macro: EX_OVF_TRAP_EN
//   When defined, signed overflow on add/sub raises ovf_out and suppresses
//   the register write and memory write of the overflowing instruction.
//   When undefined, arithmetic wraps silently and ovf_out does not exist.
//
// Ports
//   clk                          pipeline clock, rising edge
//   reset                        synchronous active-high, clears all outputs
//   flush                        load a bubble instead of the current instr
//   regDst, memRead, memtoReg,
//   memWrite, aluSrc, regWrite   ID/EX control bits
//   aluop[1:0]                   ALU op class
//   read_data1/2[DATA_W-1:0]     ID/EX register operands (rs / rt)
//   sign_ext[DATA_W-1:0]         immediate; [5:0] funct, [10:6] shamt
//   reg_rs/rt/rd[REG_W-1:0]      ID/EX register indices
//   wb_regWrite, wb_rd, wb_data  WB stage write-back port (forwarding source)
//   memRead_out, memtoReg_out,
//   memWrite_out, regWrite_out   registered control
//   alu_result_out               registered ALU result
//   write_data_out               registered store data (forwarded rt)
//   dest_reg_out                 registered destination (rd if regDst else rt)
//   zero_out                     registered ALU-result-is-zero flag
//   ovf_out                      registered overflow flag (EX_OVF_TRAP_EN only)
// -----------------------------------------------------------------------------
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              regDst,
  input  logic              memRead,
  input  logic              memtoReg,
  input  logic              memWrite,
  input  logic              aluSrc,
  input  logic              regWrite,
  input  logic [1:0]        aluop,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] sign_ext,
  input  logic [REG_W-1:0]  reg_rs,
  input  logic [REG_W-1:0]  reg_rt,
  input  logic [REG_W-1:0]  reg_rd,
  input  logic              wb_regWrite,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              memRead_out,
  output logic              memtoReg_out,
  output logic              memWrite_out,
  output logic              regWrite_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] write_data_out,
  output logic [REG_W-1:0]  dest_reg_out,
  output logic              zero_out
`ifdef EX_OVF_TRAP_EN
  ,
  output logic              ovf_out
`endif
);

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL
  } alu_ctl_e;

  // aluop 10 defers to funct; unknown funct codes fall back to add.
  function automatic alu_ctl_e alu_decode(input logic [1:0] op, input logic [5:0] funct);
    alu_ctl_e ctl;
    ctl = ALU_ADD;
    case (op)
      2'b00: ctl = ALU_ADD;
      2'b01: ctl = ALU_SUB;
      2'b11: ctl = ALU_AND;
      default: begin
        case (funct)
          6'b100000: ctl = ALU_ADD;
          6'b100010: ctl = ALU_SUB;
          6'b100100: ctl = ALU_AND;
          6'b100101: ctl = ALU_OR;
          6'b101010: ctl = ALU_SLT;
          6'b000000: ctl = ALU_SLL;
          default:   ctl = ALU_ADD;
        endcase
      end
    endcase
    return ctl;
  endfunction

  // EX/MEM result beats WB; register $0 never forwards.
  function automatic logic [DATA_W-1:0] fwd_select(
    input logic [REG_W-1:0]  src,
    input logic [DATA_W-1:0] reg_val,
    input logic              mem_wr,
    input logic [REG_W-1:0]  mem_dst,
    input logic [DATA_W-1:0] mem_val,
    input logic              wb_wr,
    input logic [REG_W-1:0]  wb_dst,
    input logic [DATA_W-1:0] wb_val
  );
    logic [DATA_W-1:0] val;
    val = reg_val;
    if (mem_wr && (mem_dst != '0) && (mem_dst == src))
      val = mem_val;
    else if (wb_wr && (wb_dst != '0) && (wb_dst == src))
      val = wb_val;
    return val;
  endfunction

  // sll shifts the forwarded rt value, not the ALU B mux output.
  function automatic logic [DATA_W-1:0] alu_compute(
    input alu_ctl_e                 ctl,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic        [DATA_W-1:0] shift_src,
    input logic        [4:0]        shamt
  );
    logic [DATA_W-1:0] res;
    case (ctl)
      ALU_SUB: res = a - b;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_SLT: res = (a < b) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
      ALU_SLL: res = shift_src << shamt;
      default: res = a + b;
    endcase
    return res;
  endfunction

`ifdef EX_OVF_TRAP_EN
  // Two's-complement overflow: operands (after negation for sub) share a sign
  // that the wrapped result does not.
  function automatic logic add_sub_ovf(
    input alu_ctl_e          ctl,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] res
  );
    logic ovf;
    case (ctl)
      ALU_ADD: ovf = (a[DATA_W-1] == b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
      ALU_SUB: ovf = (a[DATA_W-1] != b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
      default: ovf = 1'b0;
    endcase
    return ovf;
  endfunction
`endif

  logic signed [DATA_W-1:0] fwd_a_p0;
  logic signed [DATA_W-1:0] fwd_b_p0;
  logic signed [DATA_W-1:0] alu_b_p0;
  logic        [DATA_W-1:0] alu_res_p0;
  alu_ctl_e                 alu_ctl_p0;
  logic        [REG_W-1:0]  dest_p0;
  logic                     zero_p0;
  logic                     regWrite_p0;
  logic                     memWrite_p0;
`ifdef EX_OVF_TRAP_EN
  logic                     ovf_p0;
  logic                     ovf_p1;
`endif

  logic                     memRead_p1;
  logic                     memtoReg_p1;
  logic                     memWrite_p1;
  logic                     regWrite_p1;
  logic        [DATA_W-1:0] alu_result_p1;
  logic        [DATA_W-1:0] write_data_p1;
  logic        [REG_W-1:0]  dest_reg_p1;
  logic                     zero_p1;

  // ---- p0: execute (forwarding, ALU, destination select) ----
  always_comb begin
    fwd_a_p0 = fwd_select(reg_rs, read_data1, regWrite_p1, dest_reg_p1, alu_result_p1,
                          wb_regWrite, wb_rd, wb_data);
    fwd_b_p0 = fwd_select(reg_rt, read_data2, regWrite_p1, dest_reg_p1, alu_result_p1,
                          wb_regWrite, wb_rd, wb_data);
    alu_b_p0    = aluSrc ? sign_ext : fwd_b_p0;
    alu_ctl_p0  = alu_decode(aluop, sign_ext[5:0]);
    alu_res_p0  = alu_compute(alu_ctl_p0, fwd_a_p0, alu_b_p0, fwd_b_p0, sign_ext[10:6]);
    zero_p0     = (alu_res_p0 == '0);
    dest_p0     = regDst ? reg_rd : reg_rt;
`ifdef EX_OVF_TRAP_EN
    ovf_p0      = add_sub_ovf(alu_ctl_p0, fwd_a_p0, alu_b_p0, alu_res_p0);
    regWrite_p0 = regWrite & ~ovf_p0;
    memWrite_p0 = memWrite & ~ovf_p0;
`else
    regWrite_p0 = regWrite;
    memWrite_p0 = memWrite;
`endif
  end

  // ---- p1: EX/MEM register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      memRead_p1    <= 1'b0;
      memtoReg_p1   <= 1'b0;
      memWrite_p1   <= 1'b0;
      regWrite_p1   <= 1'b0;
      alu_result_p1 <= '0;
      write_data_p1 <= '0;
      dest_reg_p1   <= '0;
      zero_p1       <= 1'b0;
`ifdef EX_OVF_TRAP_EN
      ovf_p1        <= 1'b0;
`endif
    end else if (flush) begin
      // A bubble carries a zero result, so its zero flag reads 1.
      memRead_p1    <= 1'b0;
      memtoReg_p1   <= 1'b0;
      memWrite_p1   <= 1'b0;
      regWrite_p1   <= 1'b0;
      alu_result_p1 <= '0;
      write_data_p1 <= '0;
      dest_reg_p1   <= '0;
      zero_p1       <= 1'b1;
`ifdef EX_OVF_TRAP_EN
      ovf_p1        <= 1'b0;
`endif
    end else begin
      memRead_p1    <= memRead;
      memtoReg_p1   <= memtoReg;
      memWrite_p1   <= memWrite_p0;
      regWrite_p1   <= regWrite_p0;
      alu_result_p1 <= alu_res_p0;
      write_data_p1 <= fwd_b_p0;
      dest_reg_p1   <= dest_p0;
      zero_p1       <= zero_p0;
`ifdef EX_OVF_TRAP_EN
      ovf_p1        <= ovf_p0;
`endif
    end
  end

  assign memRead_out    = memRead_p1;
  assign memtoReg_out   = memtoReg_p1;
  assign memWrite_out   = memWrite_p1;
  assign regWrite_out   = regWrite_p1;
  assign alu_result_out = alu_result_p1;
  assign write_data_out = write_data_p1;
  assign dest_reg_out   = dest_reg_p1;
  assign zero_out       = zero_p1;
`ifdef EX_OVF_TRAP_EN
  assign ovf_out        = ovf_p1;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed scenarios with fixed expected values,
// followed by randomized traffic checked against a behavioural model.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        regDst, memRead, memtoReg, memWrite, aluSrc, regWrite;
  logic [1:0]  aluop;
  logic [31:0] read_data1, read_data2, sign_ext;
  logic [4:0]  reg_rs, reg_rt, reg_rd;
  logic        wb_regWrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        memRead_out, memtoReg_out, memWrite_out, regWrite_out;
  logic [31:0] alu_result_out, write_data_out;
  logic [4:0]  dest_reg_out;
  logic        zero_out;
`ifdef EX_OVF_TRAP_EN
  logic        ovf_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the EX/MEM register contents.
  logic        m_memRead, m_memtoReg, m_memWrite, m_regWrite;
  logic [31:0] m_alu, m_wd;
  logic [4:0]  m_dest;
  logic        m_zero, m_ovf;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .regDst(regDst), .memRead(memRead), .memtoReg(memtoReg), .memWrite(memWrite),
    .aluSrc(aluSrc), .regWrite(regWrite), .aluop(aluop),
    .read_data1(read_data1), .read_data2(read_data2), .sign_ext(sign_ext),
    .reg_rs(reg_rs), .reg_rt(reg_rt), .reg_rd(reg_rd),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .memRead_out(memRead_out), .memtoReg_out(memtoReg_out),
    .memWrite_out(memWrite_out), .regWrite_out(regWrite_out),
    .alu_result_out(alu_result_out), .write_data_out(write_data_out),
    .dest_reg_out(dest_reg_out), .zero_out(zero_out)
`ifdef EX_OVF_TRAP_EN
    , .ovf_out(ovf_out)
`endif
  );

  always #5 clk = ~clk;

  // Architectural view of one EX step: pick operand values as the register
  // file would see them after pending writes, do the arithmetic in 64-bit
  // integers, and detect overflow as "true sum out of 32-bit signed range".
  task automatic model_tick();
    logic [31:0] fa, fb, bsel, res;
    logic [5:0]  fn;
    logic [4:0]  sh;
    longint      s;
    int          op;
    logic        ov, rw, mw;
    longint      maxv = 64'sd2147483647;
    longint      minv = -64'sd2147483648;
    if (reset) begin
      {m_memRead, m_memtoReg, m_memWrite, m_regWrite} = 4'b0;
      m_alu = 0; m_wd = 0; m_dest = 0; m_zero = 0; m_ovf = 0;
    end else if (flush) begin
      {m_memRead, m_memtoReg, m_memWrite, m_regWrite} = 4'b0;
      m_alu = 0; m_wd = 0; m_dest = 0; m_zero = 1; m_ovf = 0;
    end else begin
      if (m_regWrite && m_dest != 0 && m_dest == reg_rs)      fa = m_alu;
      else if (wb_regWrite && wb_rd != 0 && wb_rd == reg_rs)  fa = wb_data;
      else                                                    fa = read_data1;
      if (m_regWrite && m_dest != 0 && m_dest == reg_rt)      fb = m_alu;
      else if (wb_regWrite && wb_rd != 0 && wb_rd == reg_rt)  fb = wb_data;
      else                                                    fb = read_data2;
      bsel = aluSrc ? sign_ext : fb;
      fn = sign_ext[5:0];
      sh = sign_ext[10:6];
      // 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sll
      case (aluop)
        2'b00: op = 0;
        2'b01: op = 1;
        2'b11: op = 2;
        default: op = (fn == 6'h22) ? 1 : (fn == 6'h24) ? 2 : (fn == 6'h25) ? 3 :
                      (fn == 6'h2a) ? 4 : (fn == 6'h00) ? 5 : 0;
      endcase
      ov = 0;
      s  = 0;
      case (op)
        0: s = longint'($signed(fa)) + longint'($signed(bsel));
        1: s = longint'($signed(fa)) - longint'($signed(bsel));
        default: s = 0;
      endcase
      case (op)
        0, 1: begin res = s[31:0]; ov = (s > maxv) || (s < minv); end
        2: res = fa & bsel;
        3: res = fa | bsel;
        4: res = ($signed(fa) < $signed(bsel)) ? 32'd1 : 32'd0;
        default: res = fb << sh;
      endcase
`ifdef EX_OVF_TRAP_EN
      rw = regWrite & ~ov;
      mw = memWrite & ~ov;
      m_ovf = ov;
`else
      rw = regWrite;
      mw = memWrite;
      m_ovf = 0;
`endif
      m_memRead = memRead; m_memtoReg = memtoReg; m_memWrite = mw; m_regWrite = rw;
      m_alu = res; m_wd = fb; m_dest = regDst ? reg_rd : reg_rt; m_zero = (res == 0);
    end
  endtask

  task automatic tick();
    model_tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    reset = 0; flush = 0;
    regDst = 0; memRead = 0; memtoReg = 0; memWrite = 0; aluSrc = 0; regWrite = 0;
    aluop = 2'b00; read_data1 = 0; read_data2 = 0; sign_ext = 0;
    reg_rs = 0; reg_rt = 0; reg_rd = 0;
    wb_regWrite = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic test_reset();
    logic [42:0] outs;
    clear_inputs();
    reset = 1; flush = 1;
    regDst = 1; memRead = 1; memtoReg = 1; memWrite = 1; regWrite = 1; aluop = 2'b10;
    read_data1 = 32'h1234; read_data2 = 32'h55; sign_ext = 32'h20;
    reg_rs = 1; reg_rt = 2; reg_rd = 3;
    tick();
    tick();
    outs = {memRead_out, memtoReg_out, memWrite_out, regWrite_out, alu_result_out,
            dest_reg_out, zero_out};
    n_checks++;
    if (outs !== 43'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    n_checks++;
    if (write_data_out !== 32'd0) begin
      n_fail++; $display("FAIL reset_write_data: got %h expected 0", write_data_out);
    end
`ifdef EX_OVF_TRAP_EN
    n_checks++;
    if (ovf_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf_out);
    end
`endif
    reset = 0; flush = 0; memRead = 0; memtoReg = 0; memWrite = 0;
    read_data1 = 5; read_data2 = 7;
    tick();
    n_checks++;
    if (alu_result_out !== 32'd12 || zero_out !== 1'b0) begin
      n_fail++; $display("FAIL add_5_7: got %h zero %b expected 0000000c zero 0", alu_result_out, zero_out);
    end
    n_checks++;
    if (dest_reg_out !== 5'd3 || regWrite_out !== 1'b1) begin
      n_fail++; $display("FAIL add_dest: got %0d rw %b expected 3 rw 1", dest_reg_out, regWrite_out);
    end
  endtask

  task automatic test_ex_mem_forward();
    clear_inputs();
    aluSrc = 1; sign_ext = 32'h10; reg_rt = 3; regWrite = 1;
    tick();
    n_checks++;
    if (alu_result_out !== 32'h10 || dest_reg_out !== 5'd3) begin
      n_fail++; $display("FAIL fwd_producer: got %h dest %0d expected 00000010 dest 3", alu_result_out, dest_reg_out);
    end
    reg_rs = 3; read_data1 = 0; sign_ext = 32'h1; reg_rt = 5;
    tick();
    n_checks++;
    if (alu_result_out !== 32'h11) begin
      n_fail++; $display("FAIL fwd_ex_mem: got %h expected 00000011", alu_result_out);
    end
  endtask

  task automatic test_priority_zero();
    clear_inputs();
    aluSrc = 1; regWrite = 1; sign_ext = 32'h8; reg_rt = 4;
    tick();
    reg_rs = 4; read_data1 = 0; sign_ext = 0; reg_rt = 6;
    wb_regWrite = 1; wb_rd = 4; wb_data = 9;
    tick();
    n_checks++;
    if (alu_result_out !== 32'h8) begin
      n_fail++; $display("FAIL fwd_priority: got %h expected 00000008", alu_result_out);
    end
    tick();
    n_checks++;
    if (alu_result_out !== 32'h9) begin
      n_fail++; $display("FAIL fwd_wb: got %h expected 00000009", alu_result_out);
    end
    wb_regWrite = 0; reg_rs = 7; read_data1 = 32'h77; reg_rt = 0;
    tick();
    n_checks++;
    if (alu_result_out !== 32'h77 || dest_reg_out !== 5'd0 || regWrite_out !== 1'b1) begin
      n_fail++; $display("FAIL r0_producer: got %h dest %0d rw %b expected 00000077 dest 0 rw 1",
                         alu_result_out, dest_reg_out, regWrite_out);
    end
    reg_rs = 0; read_data1 = 5; reg_rt = 2;
    wb_regWrite = 1; wb_rd = 0; wb_data = 32'h99;
    tick();
    n_checks++;
    if (alu_result_out !== 32'h5) begin
      n_fail++; $display("FAIL r0_no_forward: got %h expected 00000005", alu_result_out);
    end
  endtask

  task automatic test_store_beq();
    clear_inputs();
    aluSrc = 1; sign_ext = 4; reg_rs = 8; read_data1 = 32'h1000;
    reg_rt = 9; read_data2 = 0; memWrite = 1;
    wb_regWrite = 1; wb_rd = 9; wb_data = 32'hAB;
    tick();
    n_checks++;
    if (alu_result_out !== 32'h1004 || write_data_out !== 32'hAB || memWrite_out !== 1'b1) begin
      n_fail++; $display("FAIL store: got addr %h data %h mw %b expected 00001004 000000ab 1",
                         alu_result_out, write_data_out, memWrite_out);
    end
    clear_inputs();
    aluop = 2'b01; reg_rs = 10; reg_rt = 11; read_data1 = 32'h1234; read_data2 = 32'h1234;
    tick();
    n_checks++;
    if (zero_out !== 1'b1 || alu_result_out !== 32'h0) begin
      n_fail++; $display("FAIL beq_equal: got zero %b res %h expected zero 1 res 0", zero_out, alu_result_out);
    end
  endtask

  task automatic test_flush();
    logic [7:0] ctl;
    clear_inputs();
    aluop = 2'b10; sign_ext = 32'h20; regDst = 1; reg_rs = 1; reg_rt = 2; reg_rd = 12;
    read_data1 = 3; read_data2 = 4; regWrite = 1;
    tick();
    n_checks++;
    if (alu_result_out !== 32'h7) begin
      n_fail++; $display("FAIL pre_flush_add: got %h expected 00000007", alu_result_out);
    end
    flush = 1; memRead = 1; memtoReg = 1; memWrite = 1; read_data1 = 9;
    tick();
    ctl = {memRead_out, memtoReg_out, memWrite_out, regWrite_out, zero_out, 3'b0};
    n_checks++;
    if (ctl !== 8'b0000_1000 || dest_reg_out !== 5'd0) begin
      n_fail++; $display("FAIL flush_bubble: got ctl %b dest %0d expected 00001000 dest 0", ctl, dest_reg_out);
    end
    n_checks++;
    if (alu_result_out !== 32'h0 || write_data_out !== 32'h0) begin
      n_fail++; $display("FAIL flush_data: got %h %h expected 0 0", alu_result_out, write_data_out);
    end
    clear_inputs();
    aluop = 2'b10; sign_ext = 32'h20; regDst = 1; regWrite = 1;
    reg_rs = 12; reg_rt = 13; reg_rd = 14; read_data1 = 32'h20; read_data2 = 3;
    tick();
    n_checks++;
    if (alu_result_out !== 32'h23 || dest_reg_out !== 5'd14 || regWrite_out !== 1'b1) begin
      n_fail++; $display("FAIL post_flush: got %h dest %0d rw %b expected 00000023 dest 14 rw 1",
                         alu_result_out, dest_reg_out, regWrite_out);
    end
    reset = 1; flush = 1;
    tick();
    n_checks++;
    if (zero_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_over_flush: got zero %b expected 0", zero_out);
    end
    reset = 0; flush = 0;
  endtask

  task automatic test_overflow();
    clear_inputs();
    aluSrc = 1; sign_ext = 1; reg_rs = 15; read_data1 = 32'h7FFFFFFF; reg_rt = 16; regWrite = 1;
    tick();
    n_checks++;
    if (alu_result_out !== 32'h80000000) begin
      n_fail++; $display("FAIL ovf_add_wrap: got %h expected 80000000", alu_result_out);
    end
`ifdef EX_OVF_TRAP_EN
    n_checks++;
    if (ovf_out !== 1'b1 || regWrite_out !== 1'b0) begin
      n_fail++; $display("FAIL ovf_add_trap: got ovf %b rw %b expected ovf 1 rw 0", ovf_out, regWrite_out);
    end
`else
    n_checks++;
    if (regWrite_out !== 1'b1) begin
      n_fail++; $display("FAIL ovf_add_silent: got rw %b expected 1", regWrite_out);
    end
`endif
    aluop = 2'b01; reg_rs = 17; read_data1 = 32'h80000000; reg_rt = 18; memWrite = 1;
    tick();
    n_checks++;
    if (alu_result_out !== 32'h7FFFFFFF) begin
      n_fail++; $display("FAIL ovf_sub_wrap: got %h expected 7fffffff", alu_result_out);
    end
`ifdef EX_OVF_TRAP_EN
    n_checks++;
    if (ovf_out !== 1'b1 || regWrite_out !== 1'b0 || memWrite_out !== 1'b0) begin
      n_fail++; $display("FAIL ovf_sub_trap: got ovf %b rw %b mw %b expected 1 0 0", ovf_out, regWrite_out, memWrite_out);
    end
`else
    n_checks++;
    if (regWrite_out !== 1'b1 || memWrite_out !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sub_silent: got rw %b mw %b expected 1 1", regWrite_out, memWrite_out);
    end
`endif
  endtask

  task automatic test_random();
    logic [5:0]  functs [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h11};
    logic [31:0] r;
    logic [78:0] got, exp;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      r = $urandom();
      {regDst, memRead, memtoReg, memWrite, aluSrc, regWrite} = r[5:0];
      aluop = r[7:6];
      r = $urandom();
      sign_ext = {r[31:11], r[10:6], functs[$urandom_range(0, 6)]};
      read_data1 = $urandom();
      read_data2 = $urandom();
      case ($urandom_range(0, 5))
        0: read_data1 = 32'h7FFFFFFF;
        1: read_data1 = 32'h80000000;
        2: read_data2 = read_data1;
        default: ;
      endcase
      reg_rs = 5'($urandom_range(0, 7));
      reg_rt = 5'($urandom_range(0, 7));
      reg_rd = 5'($urandom_range(0, 7));
      wb_regWrite = 1'($urandom_range(0, 1));
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom();
      tick();
      got = {memRead_out, memtoReg_out, memWrite_out, regWrite_out, alu_result_out,
             write_data_out, dest_reg_out, zero_out, 1'b0};
      exp = {m_memRead, m_memtoReg, m_memWrite, m_regWrite, m_alu, m_wd, m_dest, m_zero, 1'b0};
`ifdef EX_OVF_TRAP_EN
      got[0] = ovf_out;
      exp[0] = m_ovf;
`endif
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL random_%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ex_mem_forward();
    test_priority_zero();
    test_store_beq();
    test_flush();
    test_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register for the 5-stage MIPS pipeline.
- Consumes the ID/EX register outputs and applies MEM and WB forwarding to the operands.
- Decodes ALU control from aluop/funct, runs the ALU, and picks the destination register.
- Registers the results into EX/MEM for the memory stage.
- One cycle latency from ID/EX outputs to EX/MEM outputs.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_W, 5, register-index width.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high; clears all outputs
- flush  in  1  on the next edge, load a bubble instead of the current instruction
- regDst, memRead, memtoReg, memWrite, aluSrc, regWrite  in  1 each  ID/EX control
- aluop  in  2  ALU op class from ID/EX
- read_data1, read_data2  in  32 each  ID/EX register operands
- sign_ext  in  32  ID/EX immediate; [5:0]=funct, [10:6]=shamt
- reg_rs, reg_rt, reg_rd  in  5 each  ID/EX register indices
- wb_regWrite  in  1  WB stage write enable
- wb_rd  in  5  WB stage destination
- wb_data  in  32  WB stage write-back value
- memRead_out, memtoReg_out, memWrite_out, regWrite_out  out  1 each  registered control
- alu_result_out  out  32  registered ALU result
- write_data_out  out  32  registered store data (forwarded rt value)
- dest_reg_out  out  5  registered destination: rd if regDst, else rt
- zero_out  out  1  registered ALU-result-equals-zero flag
- ovf_out  out  1  present only with EX_OVF_TRAP_EN

Behaviour:
- Reset: at a rising clk edge with reset=1, every output goes to 0, including ovf_out. Reset overrides flush.
- Flush: at an edge with flush=1 and reset=0, all control outputs and ovf_out go to 0. Data outputs and dest_reg_out also go to 0. zero_out goes to 1, since the result is 0.
- Otherwise, every output captures the combinational EX result at each edge. There is no stall input; the stage advances every cycle.
- Forward A (operand A):
  - Use alu_result_out if regWrite_out=1, dest_reg_out!=0 and dest_reg_out==reg_rs.
  - Else use wb_data if wb_regWrite=1, wb_rd!=0 and wb_rd==reg_rs.
  - Else use read_data1.
- Forward B: the same rule using reg_rt and read_data2. The result is fwdB.
- EX/MEM forwarding has priority over WB forwarding. Register $0 is never forwarded.
- ALU B input is sign_ext if aluSrc=1, else fwdB.
- write_data_out is always fwdB.
- ALU control:
  - aluop 00 → add
  - aluop 01 → sub
  - aluop 11 → and
  - aluop 10 → decode funct:
    - 100000 add
    - 100010 sub
    - 100100 and
    - 100101 or
    - 101010 slt
    - 000000 sll
    - any other funct → add
- Arithmetic:
  - add/sub wrap modulo 2^32.
  - slt compares signed and returns 32'd1 or 32'd0.
  - sll shifts fwdB left by shamt (0–31), ignoring the ALU B mux.
- zero_out = (ALU result == 0), registered together with alu_result_out.
- Simultaneous match on both EX/MEM and WB → the EX/MEM value wins.
- reg_rs==reg_rt with a match → both operands take the same forwarded value.

Optional Feature:
- Macro: EX_OVF_TRAP_EN.
- Defined:
  - ovf_out port exists.
  - Signed overflow on add or sub (including aluop 00/01) sets ovf_out=1 for that instruction.
  - Overflow forces regWrite_out=0 and memWrite_out=0.
  - alu_result_out still holds the wrapped sum.
- Undefined:
  - ovf_out port absent.
  - Overflow wraps silently; control outputs pass through unchanged.

Test Plan:
- Reset: reset=1 for 2 edges with non-zero inputs → all outputs 0. Deassert; add 5+7 (aluop 10, funct 100000) → alu_result_out=12, zero_out=0.
- EX/MEM forward: instr1 writes r3=0x10. Next cycle instr2 reads rs=3 with read_data1=0 and adds 1 → alu_result_out=0x11.
- Priority and $0:
  - EX/MEM dest=4 value 8 and WB wb_rd=4 wb_data=9 both match rs=4 → EX/MEM value 8 used.
  - dest=0 with regWrite=1 and reg_rs=0 → read_data1 used.
- Store and beq:
  - sw with aluSrc=1, sign_ext=4, WB-forwarded rt=0xAB → alu_result_out=base+4, write_data_out=0xAB, memWrite_out=1.
  - beq with equal operands (aluop 01) → zero_out=1.
- Flush mid-stream: flush=1 on the edge after an add → all controls 0, zero_out=1, dest_reg_out=0. The next instruction proceeds normally.
- EX_OVF_TRAP_EN: 0x7FFFFFFF+1 → ovf_out=1, regWrite_out=0, alu_result_out=0x80000000. Without the macro → regWrite_out=1.
